// File: rtl/operand_fetch.sv
// Operand fetch stage: issues register-file reads for one decoded instruction,
// captures the registered read data with writeback bypass, and hands the bundle to execute.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              out_ready,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_regwrt,
    input  logic [OP_W-1:0]   in_opcode,
    output logic [ADDR_W-1:0] out_rf_rs,
    output logic [ADDR_W-1:0] out_rf_rt,
    input  logic [DATA_W-1:0] in_rf_rsval,
    input  logic [DATA_W-1:0] in_rf_rtval,
    input  logic              in_wb_regwrt,
    input  logic [ADDR_W-1:0] in_wb_rd,
    input  logic [DATA_W-1:0] in_wb_val,
    output logic              out_valid,
    input  logic              in_ready,
    output logic [DATA_W-1:0] out_rsval,
    output logic [DATA_W-1:0] out_rtval,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_regwrt,
    output logic [OP_W-1:0]   out_opcode
);

    typedef enum logic [1:0] {IDLE, READ, CAPT, VALID} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rf_rs_q, rf_rs_d;
    logic [ADDR_W-1:0] rf_rt_q, rf_rt_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic              regwrt_q, regwrt_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [DATA_W-1:0] rsval_q, rsval_d;
    logic [DATA_W-1:0] rtval_q, rtval_d;

    logic wb_hit_rs, wb_hit_rt;

    assign wb_hit_rs = in_wb_regwrt && (in_wb_rd == rf_rs_q);
    assign wb_hit_rt = in_wb_regwrt && (in_wb_rd == rf_rt_q);

    always_comb begin
        state_d  = state_q;
        rf_rs_d  = rf_rs_q;
        rf_rt_d  = rf_rt_q;
        rd_d     = rd_q;
        regwrt_d = regwrt_q;
        opcode_d = opcode_q;
        rsval_d  = rsval_q;
        rtval_d  = rtval_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rf_rs_d  = in_rs;
                    rf_rt_d  = in_rt;
                    rd_d     = in_rd;
                    regwrt_d = in_regwrt;
                    opcode_d = in_opcode;
                    state_d  = READ;
                end
            end
            // File samples the addresses at the end of this cycle.
            READ: state_d = CAPT;
            CAPT: begin
                rsval_d = wb_hit_rs ? in_wb_val : in_rf_rsval;
                rtval_d = wb_hit_rt ? in_wb_val : in_rf_rtval;
                state_d = VALID;
            end
            VALID: begin
                if (in_ready) begin
                    state_d = IDLE;
                end else begin
                    // Keep held operands coherent with writes landing while stalled.
                    if (wb_hit_rs) rsval_d = in_wb_val;
                    if (wb_hit_rt) rtval_d = in_wb_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rf_rs_q  <= '0;
            rf_rt_q  <= '0;
            rd_q     <= '0;
            regwrt_q <= 1'b0;
            opcode_q <= '0;
            rsval_q  <= '0;
            rtval_q  <= '0;
        end else begin
            state_q  <= state_d;
            rf_rs_q  <= rf_rs_d;
            rf_rt_q  <= rf_rt_d;
            rd_q     <= rd_d;
            regwrt_q <= regwrt_d;
            opcode_q <= opcode_d;
            rsval_q  <= rsval_d;
            rtval_q  <= rtval_d;
        end
    end

    assign out_ready  = (state_q == IDLE);
    assign out_valid  = (state_q == VALID);
    assign out_rf_rs  = rf_rs_q;
    assign out_rf_rt  = rf_rt_q;
    assign out_rd     = rd_q;
    assign out_regwrt = regwrt_q;
    assign out_opcode = opcode_q;
    assign out_rsval  = rsval_q;
    assign out_rtval  = rtval_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a write-before-read register file model
// driven by the same writeback port the DUT snoops.
module tb_operand_fetch;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int OP_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] in_rs, in_rt, in_rd;
    logic              in_regwrt;
    logic [OP_W-1:0]   in_opcode;
    logic [ADDR_W-1:0] out_rf_rs, out_rf_rt;
    logic [DATA_W-1:0] in_rf_rsval, in_rf_rtval;
    logic              in_wb_regwrt;
    logic [ADDR_W-1:0] in_wb_rd;
    logic [DATA_W-1:0] in_wb_val;
    logic              out_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_rsval, out_rtval;
    logic [ADDR_W-1:0] out_rd;
    logic              out_regwrt;
    logic [OP_W-1:0]   out_opcode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .out_ready(out_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_regwrt(in_regwrt), .in_opcode(in_opcode),
        .out_rf_rs(out_rf_rs), .out_rf_rt(out_rf_rt),
        .in_rf_rsval(in_rf_rsval), .in_rf_rtval(in_rf_rtval),
        .in_wb_regwrt(in_wb_regwrt), .in_wb_rd(in_wb_rd), .in_wb_val(in_wb_val),
        .out_valid(out_valid), .in_ready(in_ready),
        .out_rsval(out_rsval), .out_rtval(out_rtval),
        .out_rd(out_rd), .out_regwrt(out_regwrt), .out_opcode(out_opcode)
    );

    // Register file: registered reads, same-cycle write visible to the read.
    logic [DATA_W-1:0] mem [64];
    always @(posedge clk) begin
        if (in_wb_regwrt) mem[in_wb_rd] <= in_wb_val;
        in_rf_rsval <= (in_wb_regwrt && in_wb_rd == out_rf_rs) ? in_wb_val : mem[out_rf_rs];
        in_rf_rtval <= (in_wb_regwrt && in_wb_rd == out_rf_rt) ? in_wb_val : mem[out_rf_rt];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        in_wb_regwrt = 1'b1; in_wb_rd = a; in_wb_val = v;
        tick();
        in_wb_regwrt = 1'b0;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                         input logic [ADDR_W-1:0] rd, input logic [OP_W-1:0] op);
        in_valid = 1'b1; in_rs = rs; in_rt = rt; in_rd = rd; in_regwrt = 1'b1; in_opcode = op;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", out_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_rsval !== 32'h0 || out_rtval !== 32'h0 || out_rf_rs !== 6'd0 || out_rd !== 6'd0)
            begin errors++; $display("FAIL reset_regs rsval %h rtval %h rf_rs %0d rd %0d exp all 0", out_rsval, out_rtval, out_rf_rs, out_rd); end
    endtask

    task automatic test_basic();
        rf_write(6'd1, 32'd8);
        rf_write(6'd2, 32'h100);
        in_ready = 1'b1;
        issue(6'd1, 6'd2, 6'd3, 4'hA);
        tick(); // T0
        in_valid = 1'b0;
        checks++; if (out_ready !== 1'b0 || out_rf_rs !== 6'd1 || out_rf_rt !== 6'd2)
            begin errors++; $display("FAIL basic_accept ready %b rf_rs %0d rf_rt %0d exp 0 1 2", out_ready, out_rf_rs, out_rf_rt); end
        tick(); // T1
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", out_valid); end
        tick(); // T2
        checks++; if (out_valid !== 1'b1 || out_rsval !== 32'd8 || out_rtval !== 32'h100)
            begin errors++; $display("FAIL basic_bundle valid %b rs %h rt %h exp 1 8 100", out_valid, out_rsval, out_rtval); end
        checks++; if (out_rd !== 6'd3 || out_opcode !== 4'hA || out_regwrt !== 1'b1)
            begin errors++; $display("FAIL basic_pass rd %0d op %h wr %b exp 3 a 1", out_rd, out_opcode, out_regwrt); end
        tick(); // T3
        checks++; if (out_valid !== 1'b0 || out_ready !== 1'b1)
            begin errors++; $display("FAIL basic_return valid %b ready %b exp 0 1", out_valid, out_ready); end
    endtask

    task automatic test_capt_bypass();
        in_ready = 1'b1;
        issue(6'd1, 6'd2, 6'd4, 4'h3);
        tick(); in_valid = 1'b0; // READ
        tick();                  // CAPT
        in_wb_regwrt = 1'b1; in_wb_rd = 6'd1; in_wb_val = 32'h55;
        tick();                  // VALID
        in_wb_regwrt = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rsval !== 32'h55 || out_rtval !== 32'h100)
            begin errors++; $display("FAIL capt_bypass valid %b rs %h rt %h exp 1 55 100", out_valid, out_rsval, out_rtval); end
        tick();
    endtask

    task automatic test_same_reg();
        rf_write(6'd5, 32'd7);
        in_ready = 1'b1;
        issue(6'd5, 6'd5, 6'd6, 4'h1);
        tick(); in_valid = 1'b0; // READ
        in_wb_regwrt = 1'b1; in_wb_rd = 6'd5; in_wb_val = 32'd9;
        tick();                  // CAPT
        in_wb_regwrt = 1'b0;
        tick();                  // VALID
        checks++; if (out_rsval !== 32'd9 || out_rtval !== 32'd9)
            begin errors++; $display("FAIL same_reg rs %h rt %h exp 9 9", out_rsval, out_rtval); end
        tick();
    endtask

    task automatic test_stall();
        // r1 = 0x55, r2 = 0x100 from earlier tests
        in_ready = 1'b0;
        issue(6'd1, 6'd2, 6'd7, 4'h5);
        tick(); in_valid = 1'b0;
        tick(); tick(); // VALID
        tick();         // stall cycle 1
        checks++; if (out_valid !== 1'b1 || out_rsval !== 32'h55 || out_rtval !== 32'h100)
            begin errors++; $display("FAIL stall_c1 valid %b rs %h rt %h exp 1 55 100", out_valid, out_rsval, out_rtval); end
        in_wb_regwrt = 1'b1; in_wb_rd = 6'd2; in_wb_val = 32'hABC;
        tick();         // stall cycle 2
        in_wb_regwrt = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rtval !== 32'hABC || out_rsval !== 32'h55)
            begin errors++; $display("FAIL stall_wb valid %b rs %h rt %h exp 1 55 abc", out_valid, out_rsval, out_rtval); end
        // a non-matching write must not disturb the bundle
        in_wb_regwrt = 1'b1; in_wb_rd = 6'd9; in_wb_val = 32'hDEAD;
        tick(); in_wb_regwrt = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_rsval !== 32'h55 || out_rtval !== 32'hABC || out_rd !== 6'd7 || out_opcode !== 4'h5)
            begin errors++; $display("FAIL stall_hold valid %b rs %h rt %h rd %0d op %h exp 1 55 abc 7 5", out_valid, out_rsval, out_rtval, out_rd, out_opcode); end
        // writeback on the handshake edge is not folded into the consumed bundle
        in_ready = 1'b1;
        in_wb_regwrt = 1'b1; in_wb_rd = 6'd1; in_wb_val = 32'h77;
        tick();
        in_wb_regwrt = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_rsval !== 32'h55)
            begin errors++; $display("FAIL stall_release valid %b ready %b rs %h exp 0 1 55", out_valid, out_ready, out_rsval); end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] rds [3];
        logic [OP_W-1:0]   ops [3];
        rds[0] = 6'd10; rds[1] = 6'd0; rds[2] = 6'd63;
        ops[0] = 4'h2;  ops[1] = 4'hF; ops[2] = 4'h0;
        in_ready = 1'b1;
        issue(6'd3, 6'd4, rds[0], ops[0]);
        for (int k = 0; k < 3; k++) begin
            // each instruction occupies IDLE, READ, CAPT, VALID: accepts 4 edges apart
            checks++; if (out_ready !== 1'b1)
                begin errors++; $display("FAIL b2b_ready_idle k=%0d got %b exp 1", k, out_ready); end
            tick();
            // present the next instruction immediately; it must be ignored until IDLE
            issue(6'(k + 20), 6'(k + 30), rds[(k + 1) % 3], ops[(k + 1) % 3]);
            tick();
            checks++; if (out_ready !== 1'b0 || out_rf_rs !== 6'(k == 0 ? 3 : k + 19))
                begin errors++; $display("FAIL b2b_busy k=%0d ready %b rf_rs %0d", k, out_ready, out_rf_rs); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_ready !== 1'b0 || out_rd !== rds[k] || out_opcode !== ops[k])
                begin errors++; $display("FAIL b2b_pass k=%0d valid %b ready %b rd %0d op %h exp 1 0 %0d %h", k, out_valid, out_ready, out_rd, out_opcode, rds[k], ops[k]); end
            tick();
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        in_ready = 1'b1;
        issue(6'd2, 6'd1, 6'd12, 4'h9);
        tick(); in_valid = 1'b0; // READ
        tick();                  // CAPT
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (out_ready !== 1'b1 || out_valid !== 1'b0 || out_rsval !== 32'h0 || out_rd !== 6'd0 || out_opcode !== 4'h0 || out_rf_rs !== 6'd0)
            begin errors++; $display("FAIL midreset ready %b valid %b rs %h rd %0d op %h rf_rs %0d exp 1 0 0 0 0 0", out_ready, out_valid, out_rsval, out_rd, out_opcode, out_rf_rs); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_stray valid %b exp 0", out_valid); end
        // r2 = 0xABC, r1 = 0x77
        issue(6'd2, 6'd1, 6'd12, 4'h9);
        tick(); in_valid = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b1 || out_rsval !== 32'hABC || out_rtval !== 32'h77 || out_rd !== 6'd12)
            begin errors++; $display("FAIL midreset_next valid %b rs %h rt %h rd %0d exp 1 abc 77 12", out_valid, out_rsval, out_rtval, out_rd); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_regwrt = 1'b0; in_opcode = '0; in_wb_regwrt = 1'b0; in_wb_rd = '0;
        in_wb_val = '0; in_ready = 1'b0;
        test_reset();
        test_basic();
        test_capt_bypass();
        test_same_reg();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
